// File: rtl/instruction_fetch.sv
// Fetch initiator for a one-cycle-latency synchronous instruction memory.
// Tags each word with its PC and hands pairs to decode through a 2-entry buffer.
module instruction_fetch #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [WIDTH-1:0] if_instr,
  output logic [WIDTH-1:0] if_pc
);

  logic [WIDTH-1:0] r_pc;
  logic             r_inflight;
  logic [WIDTH-1:0] r_inflight_pc;
  logic [WIDTH-1:0] r_buf_pc    [0:1];
  logic [WIDTH-1:0] r_buf_instr [0:1];
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [1:0]       r_count;

  logic             w_pop;
  logic             w_capture;
  logic             w_issue;
  logic [2:0]       w_occ;
  logic [WIDTH-1:0] w_redirect_target;

  assign w_pop     = if_valid && if_ready;
  assign w_capture = r_inflight && !redirect_valid;
  // Credit check: entries held plus the word returning now, less the one leaving.
  assign w_occ     = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue   = !redirect_valid && (w_occ < 3'd2);
  assign w_redirect_target = redirect_pc & ~WIDTH'(3);

  assign imem_addr = r_pc;
  assign if_valid  = (r_count != 2'd0);
  assign if_instr  = r_buf_instr[r_rd_ptr];
  assign if_pc     = r_buf_pc[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_rd_ptr      <= 1'b0;
      r_wr_ptr      <= 1'b0;
      r_count       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_buf_pc[i]    <= '0;
        r_buf_instr[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Flush: buffered and in-flight words are dropped, fetch restarts at target.
      r_pc       <= w_redirect_target;
      r_inflight <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
        r_pc          <= r_pc + WIDTH'(4);
      end
      if (w_capture) begin
        r_buf_pc[r_wr_ptr]    <= r_inflight_pc;
        r_buf_instr[r_wr_ptr] <= imem_rdata;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_capture} - {1'b0, w_pop};
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(w_capture && (r_count == 2'd2)));

endmodule
